// File: rtl/ntt_io_pkg.sv
// Op codes, load FSM states and sizing helpers shared by the NTT host load path.
package ntt_io_pkg;

  localparam logic [4:0] OP_LOAD_PARAM = 5'b00001;
  localparam logic [4:0] OP_LOAD_TW    = 5'b00010;
  localparam logic [4:0] OP_LOAD_DATA  = 5'b00011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PARAM = 2'd1,
    ST_TW    = 2'd2,
    ST_DATA  = 2'd3
  } load_state_e;

  function automatic int npe_of(input int pe_depth);
    return 32'sd1 << pe_depth;
  endfunction

  function automatic int tw_capacity(input int pe_depth, input int bram_depth);
    return npe_of(pe_depth) * (32'sd1 << bram_depth);
  endfunction

  // Word index must span both a 12-bit twiddle count and one full ring.
  function automatic int cnt_width(input int max_ring_depth);
    return (max_ring_depth + 1 > 13) ? max_ring_depth + 1 : 13;
  endfunction

endpackage

// File: rtl/ntt_bank_addr.sv
// Maps a stream word position to its one-hot PE bank and bank-local address.
module ntt_bank_addr
  import ntt_io_pkg::*;
#(
  parameter int PE_DEPTH   = 4,
  parameter int BRAM_DEPTH = 8,
  parameter int CNT_W      = 13,
  parameter int PW         = 1
) (
  input  logic                       data_mode,
  input  logic [PW-1:0]              poly_idx,
  input  logic [CNT_W-1:0]           word_idx,
  input  logic [3:0]                 ring_depth,
  output logic [(2**PE_DEPTH)-1:0]   bank_oh,
  output logic [BRAM_DEPTH-1:0]      addr
);

  localparam int NPE = 2**PE_DEPTH;

  logic [CNT_W-1:0] row_s;
  logic [CNT_W-1:0] base_s;
  logic [3:0]       shamt_s;

  // Each polynomial occupies 2^(ring_depth-PE_DEPTH) rows of every bank.
  always_comb begin
    bank_oh = NPE'(1) << word_idx[PE_DEPTH-1:0];
    row_s   = word_idx >> PE_DEPTH;
    shamt_s = ring_depth - 4'(PE_DEPTH);
    if (data_mode) begin
      base_s = CNT_W'(poly_idx) << shamt_s;
    end else begin
      base_s = '0;
    end
    addr = BRAM_DEPTH'(base_s + row_s);
  end

endmodule

// File: rtl/ntt_load_ctrl.sv
// Host load controller: decodes load op codes and scatters the din0 stream into
// parameter registers and per-PE twiddle/data BRAM banks.
module ntt_load_ctrl
  import ntt_io_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int PE_DEPTH       = 4,
  parameter int MAX_RING_DEPTH = 10,
  parameter int NPOLY          = 2,
  parameter int BRAM_DEPTH     = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [4:0]                   OP_CODE,
  input  logic                         din_valid,
  input  logic [DATA_W-1:0]            din0,
  input  logic [3:0]                   ring_depth,
  input  logic [11:0]                  tw_len,
  output logic [3:0]                   pset,
  output logic [DATA_W-1:0]            q,
  output logic [DATA_W-1:0]            n_inv,
  output logic [(2**PE_DEPTH)-1:0]     bank_we,
  output logic                         bank_sel,
  output logic [BRAM_DEPTH-1:0]        bank_addr,
  output logic [DATA_W-1:0]            bank_di,
  output logic                         busy,
  output logic                         load_done,
  output logic                         err
);

  localparam int NPE    = npe_of(PE_DEPTH);
  localparam int CNT_W  = cnt_width(MAX_RING_DEPTH);
  localparam int PW     = (NPOLY > 1) ? $clog2(NPOLY) : 1;
  localparam int TW_CAP = tw_capacity(PE_DEPTH, BRAM_DEPTH);
  localparam logic [PW-1:0] POLY_LAST = PW'(NPOLY - 1);

  load_state_e         state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]       poly_q, poly_d;
  logic [3:0]          rd_q, rd_d;
  logic [11:0]         twl_q, twl_d;
  logic [3:0]          pset_q, pset_d;
  logic [DATA_W-1:0]   q_q, q_d, n_inv_q, n_inv_d;
  logic [NPE-1:0]      bank_we_q, bank_we_d;
  logic                bank_sel_q, bank_sel_d;
  logic [BRAM_DEPTH-1:0] bank_addr_q, bank_addr_d;
  logic [DATA_W-1:0]   bank_di_q, bank_di_d;
  logic                busy_q, busy_d, load_done_q, load_done_d, err_q, err_d;

  logic [NPE-1:0]        map_we_s;
  logic [BRAM_DEPTH-1:0] map_addr_s;
  logic [CNT_W-1:0]      ring_last_s, tw_last_s;
  logic                  rd_bad_s, tw_bad_s, finish_s;

  ntt_bank_addr #(
    .PE_DEPTH   (PE_DEPTH),
    .BRAM_DEPTH (BRAM_DEPTH),
    .CNT_W      (CNT_W),
    .PW         (PW)
  ) u_map (
    .data_mode  (state_q == ST_DATA),
    .poly_idx   (poly_q),
    .word_idx   (cnt_q),
    .ring_depth (rd_q),
    .bank_oh    (map_we_s),
    .addr       (map_addr_s)
  );

  // Next-state, counter and output computation for the load FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    poly_d      = poly_q;
    rd_d        = rd_q;
    twl_d       = twl_q;
    pset_d      = pset_q;
    q_d         = q_q;
    n_inv_d     = n_inv_q;
    bank_we_d   = '0;
    bank_sel_d  = bank_sel_q;
    bank_addr_d = bank_addr_q;
    bank_di_d   = bank_di_q;
    busy_d      = busy_q;
    load_done_d = 1'b0;
    finish_s    = 1'b0;

    ring_last_s = (CNT_W'(1) << rd_q) - CNT_W'(1);
    tw_last_s   = CNT_W'(twl_q) - CNT_W'(1);
    rd_bad_s    = ({28'd0, ring_depth} < 32'(PE_DEPTH + 1)) ||
                  ({28'd0, ring_depth} > 32'(MAX_RING_DEPTH));
    tw_bad_s    = (tw_len == 12'd0) || ({20'd0, tw_len} > 32'(TW_CAP));

    if ((state_q != ST_IDLE) && (OP_CODE != 5'd0)) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end

    case (state_q)
      ST_IDLE: begin
        cnt_d  = '0;
        poly_d = '0;
        if (OP_CODE == OP_LOAD_PARAM) begin
          state_d = ST_PARAM;
          busy_d  = 1'b1;
        end else if (OP_CODE == OP_LOAD_TW) begin
          if (tw_bad_s) begin
            err_d = 1'b1;
          end else begin
            state_d = ST_TW;
            twl_d   = tw_len;
            busy_d  = 1'b1;
          end
        end else if (OP_CODE == OP_LOAD_DATA) begin
          if (rd_bad_s) begin
            err_d = 1'b1;
          end else begin
            state_d = ST_DATA;
            rd_d    = ring_depth;
            busy_d  = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PARAM: begin
        if (din_valid) begin
          case (cnt_q[1:0])
            2'd0:    pset_d  = din0[3:0];
            2'd1:    q_d     = din0;
            default: n_inv_d = din0;
          endcase
          if (cnt_q == CNT_W'(2)) begin
            finish_s = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_TW, ST_DATA: begin
        if (din_valid) begin
          bank_we_d   = map_we_s;
          bank_sel_d  = (state_q == ST_DATA);
          bank_addr_d = map_addr_s;
          bank_di_d   = din0;
          if (state_q == ST_TW) begin
            if (cnt_q == tw_last_s) begin
              finish_s = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else if (cnt_q == ring_last_s) begin
            cnt_d = '0;
            if (poly_q == POLY_LAST) begin
              finish_s = 1'b1;
            end else begin
              poly_d = poly_q + PW'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (finish_s) begin
      state_d     = ST_IDLE;
      cnt_d       = '0;
      poly_d      = '0;
      busy_d      = 1'b0;
      load_done_d = 1'b1;
    end else begin
      load_done_d = 1'b0;
    end
  end

  // State and registered outputs; reset clears everything including the sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      poly_q      <= '0;
      rd_q        <= 4'd0;
      twl_q       <= 12'd0;
      pset_q      <= 4'd0;
      q_q         <= '0;
      n_inv_q     <= '0;
      bank_we_q   <= '0;
      bank_sel_q  <= 1'b0;
      bank_addr_q <= '0;
      bank_di_q   <= '0;
      busy_q      <= 1'b0;
      load_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      poly_q      <= poly_d;
      rd_q        <= rd_d;
      twl_q       <= twl_d;
      pset_q      <= pset_d;
      q_q         <= q_d;
      n_inv_q     <= n_inv_d;
      bank_we_q   <= bank_we_d;
      bank_sel_q  <= bank_sel_d;
      bank_addr_q <= bank_addr_d;
      bank_di_q   <= bank_di_d;
      busy_q      <= busy_d;
      load_done_q <= load_done_d;
      err_q       <= err_d;
    end
  end

  assign pset      = pset_q;
  assign q         = q_q;
  assign n_inv     = n_inv_q;
  assign bank_we   = bank_we_q;
  assign bank_sel  = bank_sel_q;
  assign bank_addr = bank_addr_q;
  assign bank_di   = bank_di_q;
  assign busy      = busy_q;
  assign load_done = load_done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_ntt_load_ctrl.sv
// Scoreboard bench for ntt_load_ctrl with default parameters (16 PEs, 8-bit bank address).
module tb_ntt_load_ctrl;
  import ntt_io_pkg::*;

  typedef struct packed {
    logic        sel;
    logic [15:0] we;
    logic [7:0]  addr;
    logic [31:0] di;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  OP_CODE = 5'd0;
  logic        din_valid = 1'b0;
  logic [31:0] din0 = 32'd0;
  logic [3:0]  ring_depth = 4'd0;
  logic [11:0] tw_len = 12'd0;
  logic [3:0]  pset;
  logic [31:0] q, n_inv, bank_di;
  logic [15:0] bank_we;
  logic        bank_sel, busy, load_done, err;
  logic [7:0]  bank_addr;

  wr_t exp_q[$];
  wr_t mon_got, mon_exp, last_wr, first_wr;
  bit  first_seen = 1'b0;
  int  chk_cnt = 0, pass_cnt = 0, wr_cnt = 0, done_cnt = 0;

  ntt_load_ctrl dut (
    .clk(clk), .reset(reset), .OP_CODE(OP_CODE), .din_valid(din_valid), .din0(din0),
    .ring_depth(ring_depth), .tw_len(tw_len), .pset(pset), .q(q), .n_inv(n_inv),
    .bank_we(bank_we), .bank_sel(bank_sel), .bank_addr(bank_addr), .bank_di(bank_di),
    .busy(busy), .load_done(load_done), .err(err)
  );

  always #5 clk = ~clk;

  // Write monitor: every observed bank write is matched against the scoreboard.
  always @(negedge clk) begin
    if (bank_we !== 16'd0) begin
      mon_got = {bank_sel, bank_we, bank_addr, bank_di};
      chk_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_write: got sel=%0d we=%h addr=%0d di=%h, required no write",
                 bank_sel, bank_we, bank_addr, bank_di);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp)
          $display("FAIL write: got sel=%0d we=%h addr=%0d di=%h, required sel=%0d we=%h addr=%0d di=%h",
                   mon_got.sel, mon_got.we, mon_got.addr, mon_got.di,
                   mon_exp.sel, mon_exp.we, mon_exp.addr, mon_exp.di);
        else
          pass_cnt++;
      end
      if (!first_seen) begin
        first_wr   = mon_got;
        first_seen = 1'b1;
      end
      last_wr = mon_got;
      wr_cnt++;
    end
    if (load_done === 1'b1) done_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required test completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; OP_CODE = 5'd0; din_valid = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic issue_op(input logic [4:0] op, input logic [3:0] rd, input logic [11:0] tl);
    OP_CODE = op; ring_depth = rd; tw_len = tl;
    tick();
    OP_CODE = 5'd0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    if (gaps && ($urandom_range(0, 2) == 0)) begin
      din_valid = 1'b0;
      repeat ($urandom_range(1, 4)) tick();
    end
    din_valid = 1'b1; din0 = w;
    tick();
    din_valid = 1'b0; din0 = $urandom;
  endtask

  task automatic load_data(input int rd, input int nwords, input bit gaps,
                           input int inj_idx, input logic [4:0] inj_op);
    int per;
    per = 1 << rd;
    for (int i = 0; i < nwords; i++) begin
      int p, k;
      logic [31:0] w;
      wr_t e;
      p = i / per; k = i % per; w = $urandom;
      e.sel = 1'b1; e.we = 16'(1) << (k % 16); e.addr = 8'(p * (per / 16) + k / 16); e.di = w;
      exp_q.push_back(e);
      if (i == inj_idx) OP_CODE = inj_op;
      send_word(w, gaps);
      OP_CODE = 5'd0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    chk_cnt++;
    if (busy !== 1'b0 || load_done !== 1'b0 || err !== 1'b0)
      $display("FAIL reset_status: got busy=%b done=%b err=%b, required 0 0 0", busy, load_done, err);
    else pass_cnt++;
    chk_cnt++;
    if (bank_we !== 16'd0 || bank_sel !== 1'b0 || bank_addr !== 8'd0 || bank_di !== 32'd0)
      $display("FAIL reset_bank: got we=%h sel=%b addr=%h di=%h, required all 0", bank_we, bank_sel, bank_addr, bank_di);
    else pass_cnt++;
    chk_cnt++;
    if (pset !== 4'd0 || q !== 32'd0 || n_inv !== 32'd0)
      $display("FAIL reset_params: got pset=%h q=%h n_inv=%h, required all 0", pset, q, n_inv);
    else pass_cnt++;
  endtask

  task automatic test_param();
    issue_op(OP_LOAD_PARAM, 4'd0, 12'd0);
    chk_cnt++;
    if (busy !== 1'b1) $display("FAIL param_busy: got %b, required 1", busy); else pass_cnt++;
    send_word(32'hD, 1'b0);
    chk_cnt++;
    if (pset !== 4'hD) $display("FAIL param_pset: got %h, required d", pset); else pass_cnt++;
    send_word(32'hD01, 1'b0);
    chk_cnt++;
    if (q !== 32'd3329) $display("FAIL param_q: got %0d, required 3329", q); else pass_cnt++;
    chk_cnt++;
    if (load_done !== 1'b0) $display("FAIL param_early_done: got %b, required 0", load_done); else pass_cnt++;
    send_word(32'hCC1, 1'b0);
    chk_cnt++;
    if (n_inv !== 32'hCC1 || load_done !== 1'b1 || busy !== 1'b0 || err !== 1'b0)
      $display("FAIL param_done: got n_inv=%h done=%b busy=%b err=%b, required cc1 1 0 0", n_inv, load_done, busy, err);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (load_done !== 1'b0) $display("FAIL param_pulse: got %b, required 0", load_done); else pass_cnt++;
  endtask

  task automatic test_tw();
    int dc0, wc0;
    dc0 = done_cnt; wc0 = wr_cnt;
    issue_op(OP_LOAD_TW, 4'd0, 12'd624);
    for (int j = 0; j < 624; j++) begin
      logic [31:0] w;
      wr_t e;
      w = $urandom;
      e.sel = 1'b0; e.we = 16'(1) << (j % 16); e.addr = 8'(j / 16); e.di = w;
      exp_q.push_back(e);
      send_word(w, 1'b0);
    end
    chk_cnt++;
    if (load_done !== 1'b1 || busy !== 1'b0)
      $display("FAIL tw_done: got done=%b busy=%b, required 1 0", load_done, busy);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (exp_q.size() != 0 || wr_cnt - wc0 != 624)
      $display("FAIL tw_count: got writes=%0d pending=%0d, required 624 0", wr_cnt - wc0, exp_q.size());
    else pass_cnt++;
    chk_cnt++;
    if (last_wr.we !== 16'h8000 || last_wr.addr !== 8'd38 || last_wr.sel !== 1'b0)
      $display("FAIL tw_last: got we=%h addr=%0d sel=%b, required 8000 38 0", last_wr.we, last_wr.addr, last_wr.sel);
    else pass_cnt++;
    chk_cnt++;
    if (done_cnt - dc0 != 1) $display("FAIL tw_done_once: got %0d, required 1", done_cnt - dc0); else pass_cnt++;
  endtask

  task automatic test_data_gaps();
    int dc0, wc0;
    dc0 = done_cnt; wc0 = wr_cnt;
    issue_op(OP_LOAD_DATA, 4'd8, 12'd0);
    load_data(8, 512, 1'b1, -1, 5'd0);
    chk_cnt++;
    if (load_done !== 1'b1 || busy !== 1'b0)
      $display("FAIL data_done: got done=%b busy=%b, required 1 0", load_done, busy);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (exp_q.size() != 0 || wr_cnt - wc0 != 512 || done_cnt - dc0 != 1)
      $display("FAIL data_count: got writes=%0d pending=%0d done=%0d, required 512 0 1",
               wr_cnt - wc0, exp_q.size(), done_cnt - dc0);
    else pass_cnt++;
    chk_cnt++;
    if (last_wr.we !== 16'h8000 || last_wr.addr !== 8'd31 || last_wr.sel !== 1'b1)
      $display("FAIL data_last: got we=%h addr=%0d sel=%b, required 8000 31 1", last_wr.we, last_wr.addr, last_wr.sel);
    else pass_cnt++;
  endtask

  task automatic test_bad_ops();
    int wc0;
    do_reset();
    wc0 = wr_cnt;
    issue_op(OP_LOAD_DATA, 4'd4, 12'd0);
    chk_cnt++;
    if (err !== 1'b1 || busy !== 1'b0) $display("FAIL bad_depth_low: got err=%b busy=%b, required 1 0", err, busy);
    else pass_cnt++;
    send_word(32'h1234, 1'b0);
    send_word(32'h5678, 1'b0);
    tick();
    chk_cnt++;
    if (wr_cnt != wc0) $display("FAIL idle_no_write: got %0d writes, required 0", wr_cnt - wc0); else pass_cnt++;
    issue_op(OP_LOAD_PARAM, 4'd0, 12'd0);
    chk_cnt++;
    if (busy !== 1'b1) $display("FAIL accept_after_err: got busy=%b, required 1", busy); else pass_cnt++;
    send_word(32'h1, 1'b0); send_word(32'h2, 1'b0); send_word(32'h3, 1'b0);
    chk_cnt++;
    if (pset !== 4'h1 || q !== 32'h2 || n_inv !== 32'h3 || load_done !== 1'b1)
      $display("FAIL param_after_err: got %h %h %h done=%b, required 1 2 3 1", pset, q, n_inv, load_done);
    else pass_cnt++;
    do_reset();
    issue_op(OP_LOAD_DATA, 4'd11, 12'd0);
    chk_cnt++;
    if (err !== 1'b1 || busy !== 1'b0) $display("FAIL bad_depth_high: got err=%b busy=%b, required 1 0", err, busy);
    else pass_cnt++;
    do_reset();
    issue_op(OP_LOAD_TW, 4'd0, 12'd0);
    chk_cnt++;
    if (err !== 1'b1 || busy !== 1'b0) $display("FAIL tw_len_zero: got err=%b busy=%b, required 1 0", err, busy);
    else pass_cnt++;
    do_reset();
    issue_op(OP_LOAD_TW, 4'd0, 12'd4095);
    chk_cnt++;
    if (err !== 1'b0 || busy !== 1'b1) $display("FAIL tw_len_max: got err=%b busy=%b, required 0 1", err, busy);
    else pass_cnt++;
    do_reset();
    issue_op(5'b00100, 4'd8, 12'd5);
    issue_op(5'b11111, 4'd8, 12'd5);
    chk_cnt++;
    if (err !== 1'b0 || busy !== 1'b0) $display("FAIL core_op_idle: got err=%b busy=%b, required 0 0", err, busy);
    else pass_cnt++;
  endtask

  task automatic test_op_midload();
    int dc0, wc0;
    do_reset();
    dc0 = done_cnt; wc0 = wr_cnt;
    issue_op(OP_LOAD_DATA, 4'd5, 12'd0);
    load_data(5, 64, 1'b0, 20, 5'b00100);
    chk_cnt++;
    if (err !== 1'b1 || load_done !== 1'b1 || busy !== 1'b0)
      $display("FAIL midload_op: got err=%b done=%b busy=%b, required 1 1 0", err, load_done, busy);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (exp_q.size() != 0 || wr_cnt - wc0 != 64 || done_cnt - dc0 != 1)
      $display("FAIL midload_count: got writes=%0d pending=%0d done=%0d, required 64 0 1",
               wr_cnt - wc0, exp_q.size(), done_cnt - dc0);
    else pass_cnt++;
    do_reset();
    issue_op(OP_LOAD_DATA, 4'd5, 12'd0);
    load_data(5, 64, 1'b0, 63, OP_LOAD_PARAM);
    chk_cnt++;
    if (err !== 1'b1 || load_done !== 1'b1) $display("FAIL final_word_op: got err=%b done=%b, required 1 1", err, load_done);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (busy !== 1'b0 || exp_q.size() != 0)
      $display("FAIL final_word_op_idle: got busy=%b pending=%0d, required 0 0", busy, exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_reset_midload();
    int dc0, wc0;
    do_reset();
    issue_op(OP_LOAD_DATA, 4'd8, 12'd0);
    load_data(8, 100, 1'b0, -1, 5'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_cnt++;
    if (busy !== 1'b0 || bank_we !== 16'd0 || exp_q.size() != 0)
      $display("FAIL midload_reset: got busy=%b we=%h pending=%0d, required 0 0 0", busy, bank_we, exp_q.size());
    else pass_cnt++;
    first_seen = 1'b0;
    dc0 = done_cnt; wc0 = wr_cnt;
    issue_op(OP_LOAD_DATA, 4'd8, 12'd0);
    load_data(8, 512, 1'b0, -1, 5'd0);
    tick();
    chk_cnt++;
    if (exp_q.size() != 0 || wr_cnt - wc0 != 512 || done_cnt - dc0 != 1)
      $display("FAIL reload_count: got writes=%0d pending=%0d done=%0d, required 512 0 1",
               wr_cnt - wc0, exp_q.size(), done_cnt - dc0);
    else pass_cnt++;
    chk_cnt++;
    if (first_wr.addr !== 8'd0 || first_wr.we !== 16'h0001 || first_wr.sel !== 1'b1)
      $display("FAIL reload_first: got addr=%0d we=%h sel=%b, required 0 0001 1", first_wr.addr, first_wr.we, first_wr.sel);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_param();
    test_tw();
    test_data_gaps();
    test_bad_ops();
    test_op_midload();
    test_reset_midload();
    repeat (3) tick();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
